mem_arbiter: RTL and testbench

// - Two-port arbiter/sequencer in front of the single-port 10-bit data RAM. Port 0 is the CPU load/store stage; port 1 is the loader/IO side.
// - Grants one requester at a time and drives the RAM control trio (address, write data, ldst_en).
// - Registers read data and returns it with a one-cycle done pulse.
// - Sits between the execute/memory stage and the RAM; the CPU never drives the RAM directly.

---
 rtl/mem_arbiter.sv | 159 +++++++++++++++
 tb/tb_mem_arbiter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port arbiter/sequencer in front of the single-port data RAM: IDLE -> ACCESS -> RESP.
// Define MEM_ARB_FIXED_PRIO_EN for fixed priority (port 0 wins ties); default is round-robin.
module mem_arbiter #(
  parameter int AW = 10,
  parameter int DW = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          r0_req,
  input  logic          r0_we,
  input  logic [AW-1:0] r0_addr,
  input  logic [DW-1:0] r0_wdata,
  output logic          r0_gnt,
  output logic          r0_done,
  output logic [DW-1:0] r0_rdata,
  input  logic          r1_req,
  input  logic          r1_we,
  input  logic [AW-1:0] r1_addr,
  input  logic [DW-1:0] r1_wdata,
  output logic          r1_gnt,
  output logic          r1_done,
  output logic [DW-1:0] r1_rdata,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  output logic [1:0]    ram_ldst_en,
  input  logic [DW-1:0] ram_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t        state_r;
  logic          win_r;
  logic          we_r;
  logic          any_req_s;
  logic          pick_s;
  logic          sel_we_s;
  logic [AW-1:0] sel_addr_s;
  logic [DW-1:0] sel_wdata_s;

`ifndef MEM_ARB_FIXED_PRIO_EN
  logic last_r;
`endif

  // Winner selection and request-field mux, consumed only when leaving IDLE
  always_comb begin
    any_req_s = r0_req | r1_req;
    pick_s    = 1'b0;
`ifdef MEM_ARB_FIXED_PRIO_EN
    if (r0_req) begin
      pick_s = 1'b0;
    end else begin
      pick_s = 1'b1;
    end
`else
    if (r0_req && r1_req) begin
      pick_s = ~last_r;
    end else if (r0_req) begin
      pick_s = 1'b0;
    end else begin
      pick_s = 1'b1;
    end
`endif
    if (pick_s) begin
      sel_we_s    = r1_we;
      sel_addr_s  = r1_addr;
      sel_wdata_s = r1_wdata;
    end else begin
      sel_we_s    = r0_we;
      sel_addr_s  = r0_addr;
      sel_wdata_s = r0_wdata;
    end
  end

`ifndef MEM_ARB_FIXED_PRIO_EN
  // Round-robin pointer: remembers the last served port, reset value favours port 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_r <= 1'b1;
    end else if (state_r == RESP) begin
      last_r <= win_r;
    end else begin
      last_r <= last_r;
    end
  end
`endif

  // Sequencer FSM; every output is a register so nothing combinational leaks from rN_* inputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      win_r       <= 1'b0;
      we_r        <= 1'b0;
      ram_addr    <= {AW{1'b0}};
      ram_wdata   <= {DW{1'b0}};
      ram_ldst_en <= 2'd0;
      r0_gnt      <= 1'b0;
      r1_gnt      <= 1'b0;
      r0_done     <= 1'b0;
      r1_done     <= 1'b0;
      r0_rdata    <= {DW{1'b0}};
      r1_rdata    <= {DW{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (any_req_s) begin
            state_r     <= ACCESS;
            win_r       <= pick_s;
            we_r        <= sel_we_s;
            ram_addr    <= sel_addr_s;
            ram_wdata   <= sel_wdata_s;
            ram_ldst_en <= sel_we_s ? 2'd3 : 2'd2;
            r0_gnt      <= ~pick_s;
            r1_gnt      <= pick_s;
          end else begin
            state_r <= IDLE;
          end
        end
        ACCESS: begin
          // Load data is captured at the edge that closes the RAM cycle
          state_r     <= RESP;
          ram_addr    <= {AW{1'b0}};
          ram_wdata   <= {DW{1'b0}};
          ram_ldst_en <= 2'd0;
          r0_gnt      <= 1'b0;
          r1_gnt      <= 1'b0;
          r0_done     <= ~win_r;
          r1_done     <= win_r;
          if (!we_r && win_r) begin
            r1_rdata <= ram_rdata;
          end else if (!we_r) begin
            r0_rdata <= ram_rdata;
          end else begin
            r0_rdata <= r0_rdata;
          end
        end
        RESP: begin
          state_r <= IDLE;
          r0_done <= 1'b0;
          r1_done <= 1'b0;
        end
        default: begin
          state_r     <= IDLE;
          ram_addr    <= {AW{1'b0}};
          ram_wdata   <= {DW{1'b0}};
          ram_ldst_en <= 2'd0;
          r0_gnt      <= 1'b0;
          r1_gnt      <= 1'b0;
          r0_done     <= 1'b0;
          r1_done     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus queues expected grants/responses, a negedge monitor checks them.
module tb_mem_arbiter;

  logic       clk;
  logic       rst_n;
  logic       r0_req, r0_we, r0_gnt, r0_done;
  logic [9:0] r0_addr, r0_wdata, r0_rdata;
  logic       r1_req, r1_we, r1_gnt, r1_done;
  logic [9:0] r1_addr, r1_wdata, r1_rdata;
  logic [9:0] ram_addr, ram_wdata, ram_rdata;
  logic [1:0] ram_ldst_en;

  typedef struct {
    bit       port;
    bit       we;
    bit [9:0] addr;
    bit [9:0] wdata;
    bit [9:0] rdata;
  } txn_t;

  txn_t gnt_q[$];
  txn_t done_q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   gnt_cyc = 0;

  logic [9:0] mem [0:1023];
  bit         mem_init_done = 1'b0;

  mem_arbiter #(.AW(10), .DW(10)) dut (
    .clk(clk), .rst_n(rst_n),
    .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_gnt(r0_gnt), .r0_done(r0_done), .r0_rdata(r0_rdata),
    .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_gnt(r1_gnt), .r1_done(r1_done), .r1_rdata(r1_rdata),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_ldst_en(ram_ldst_en),
    .ram_rdata(ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: combinational read, store committed on the negedge
  assign ram_rdata = mem[ram_addr];
  always @(negedge clk) begin
    if (!mem_init_done) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 10'h000;
      mem[10]  <= 10'h111;
      mem[20]  <= 10'h222;
      mem[200] <= 10'h0AB;
      mem_init_done <= 1'b1;
    end else if (ram_ldst_en == 2'd3) begin
      mem[ram_addr] <= ram_wdata;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops expectations whenever the DUT shows a grant or a done
  always @(negedge clk) begin
    txn_t e;
    if (rst_n) begin
      cyc++;
      if (r0_gnt || r1_gnt) begin
        if (gnt_q.size() == 0) begin
          chk("gnt_unexpected", 32'd1, 32'd0);
        end else begin
          e = gnt_q.pop_front();
          chk("gnt_excl", {31'd0, r0_gnt & r1_gnt}, 32'd0);
          chk("gnt_port", {31'd0, r1_gnt}, {31'd0, e.port});
          chk("gnt_ldst", {30'd0, ram_ldst_en}, e.we ? 32'd3 : 32'd2);
          chk("gnt_addr", {22'd0, ram_addr}, {22'd0, e.addr});
          if (e.we) chk("gnt_wdata", {22'd0, ram_wdata}, {22'd0, e.wdata});
          gnt_cyc = cyc;
        end
      end else begin
        chk("idle_ldst", {30'd0, ram_ldst_en}, 32'd0);
        chk("idle_addr", {22'd0, ram_addr}, 32'd0);
      end
      if (r0_done || r1_done) begin
        if (done_q.size() == 0) begin
          chk("done_unexpected", 32'd1, 32'd0);
        end else begin
          e = done_q.pop_front();
          chk("done_excl", {31'd0, r0_done & r1_done}, 32'd0);
          chk("done_port", {31'd0, r1_done}, {31'd0, e.port});
          chk("done_latency", cyc, gnt_cyc + 1);
          if (!e.we) chk("done_rdata", {22'd0, e.port ? r1_rdata : r0_rdata}, {22'd0, e.rdata});
        end
      end
    end
  end

  task automatic expect_txn(input bit p, input bit we, input bit [9:0] a, input bit [9:0] wd, input bit [9:0] rd);
    txn_t t;
    t.port = p; t.we = we; t.addr = a; t.wdata = wd; t.rdata = rd;
    gnt_q.push_back(t);
    done_q.push_back(t);
  endtask

  task automatic set_req(input bit p, input bit v, input bit we, input bit [9:0] a, input bit [9:0] wd);
    if (p) begin
      r1_req = v; r1_we = we; r1_addr = a; r1_wdata = wd;
    end else begin
      r0_req = v; r0_we = we; r0_addr = a; r0_wdata = wd;
    end
  endtask

  // One access from port p; drop_early releases req in the cycle after the grant
  task automatic do_access(input bit p, input bit we, input bit [9:0] a, input bit [9:0] wd,
                           input bit [9:0] rd, input bit drop_early);
    bit seen;
    seen = 1'b0;
    expect_txn(p, we, a, wd, rd);
    @(posedge clk); #1;
    set_req(p, 1'b1, we, a, wd);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (drop_early && (p ? r1_gnt : r0_gnt)) begin
        @(posedge clk); #1;
        set_req(p, 1'b0, 1'b0, 10'd0, 10'd0);
      end else if (p ? r1_done : r0_done) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) chk("access_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    set_req(p, 1'b0, 1'b0, 10'd0, 10'd0);
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    set_req(1'b0, 1'b0, 1'b0, 10'd0, 10'd0);
    set_req(1'b1, 1'b0, 1'b0, 10'd0, 10'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ldst", {30'd0, ram_ldst_en}, 32'd0);
    chk("rst_addr", {22'd0, ram_addr}, 32'd0);
    chk("rst_gnt_done", {28'd0, r0_gnt, r1_gnt, r0_done, r1_done}, 32'd0);
    chk("rst_rdata", {12'd0, r0_rdata, r1_rdata}, 32'd0);
    rst_n = 1'b1;

    // Tie held continuously: alternating grants in round-robin, port 0 only in fixed priority
    for (int i = 0; i < 4; i++) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
      expect_txn(1'b0, 1'b0, 10'd10, 10'd0, 10'h111);
`else
      if (i % 2 == 1) expect_txn(1'b1, 1'b0, 10'd20, 10'd0, 10'h222);
      else            expect_txn(1'b0, 1'b0, 10'd10, 10'd0, 10'h111);
`endif
    end
    @(posedge clk); #1;
    set_req(1'b0, 1'b1, 1'b0, 10'd10, 10'd0);
    set_req(1'b1, 1'b1, 1'b0, 10'd20, 10'd0);
    n = 0;
    for (int i = 0; i < 60 && n < 4; i++) begin
      @(negedge clk);
      if (r0_done || r1_done) n++;
    end
    if (n < 4) chk("tie_timeout", n, 32'd4);
    @(posedge clk); #1;
    set_req(1'b0, 1'b0, 1'b0, 10'd0, 10'd0);
    set_req(1'b1, 1'b0, 1'b0, 10'd0, 10'd0);
    repeat (3) @(posedge clk);

    do_access(1'b0, 1'b0, 10'd45, 10'd0, 10'h000, 1'b0);
    do_access(1'b1, 1'b1, 10'd100, 10'h2A5, 10'h000, 1'b0);
    do_access(1'b0, 1'b0, 10'd100, 10'd0, 10'h2A5, 1'b0);
    do_access(1'b0, 1'b0, 10'd10, 10'd0, 10'h111, 1'b1);
    @(negedge clk);
    chk("drop_idle_ldst", {30'd0, ram_ldst_en}, 32'd0);
    chk("drop_no_regrant", {31'd0, r0_gnt}, 32'd0);

    // Reset pulse inside the first half of a store's ACCESS cycle
    @(posedge clk); #1;
    set_req(1'b1, 1'b1, 1'b1, 10'd200, 10'h155);
    @(posedge clk); #1;
    chk("abort_gnt", {31'd0, r1_gnt}, 32'd1);
    chk("abort_ldst3", {30'd0, ram_ldst_en}, 32'd3);
    rst_n = 1'b0;
    set_req(1'b1, 1'b0, 1'b0, 10'd0, 10'd0);
    #1;
    chk("abort_ldst0", {30'd0, ram_ldst_en}, 32'd0);
    chk("abort_gnt0", {31'd0, r1_gnt}, 32'd0);
    #1 rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("abort_no_done", {30'd0, r0_done, r1_done}, 32'd0);
    end
    do_access(1'b0, 1'b0, 10'd200, 10'd0, 10'h0AB, 1'b0);

    repeat (4) @(posedge clk);
    chk("gnt_q_empty", gnt_q.size(), 32'd0);
    chk("done_q_empty", done_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
